// File: rtl/mux_tdm_n.sv
// N-input, WIDTH-bit multiplexer with registered output: manual channel select
// or time-division scan over the enabled channels, DWELL cycles per channel.
module mux_tdm_n #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int DWELL = 2,
    parameter int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SW-1:0]      s,
    input  logic [N-1:0]       mask,
    input  logic [N*WIDTH-1:0] d,
    output logic [WIDTH-1:0]   o,
    output logic [SW-1:0]      ch,
    output logic               o_valid,
    output logic               wrap
);

    localparam int CW = $clog2(DWELL) + 1;

    logic [SW-1:0]    cur;
    logic [CW-1:0]    dwell_cnt;
    logic             prev_mode;

    logic [WIDTH-1:0] lane [N];
    logic             entry;
    logic [SW-1:0]    eff;
    logic [SW-1:0]    nxt_start;
    logic [SW-1:0]    nxt;
    logic [CW-1:0]    cnt_eff;
    logic             last_dwell;
    logic             sel_ok;

    // First enabled channel at or above start, wrapping to the lowest enabled
    // one. Two priority scans instead of a rotator keep this shallow for N=16.
    function automatic logic [SW-1:0] find_from(input logic [SW-1:0] start,
                                                input logic [N-1:0]  m);
        logic [SW-1:0] r_hi;
        logic [SW-1:0] r_any;
        logic          found_hi;
        r_hi     = start;
        r_any    = start;
        found_hi = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) begin
                r_any = SW'(i);
                if (i >= int'(start)) begin
                    r_hi     = SW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        return found_hi ? r_hi : r_any;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            lane[i] = d[i*WIDTH +: WIDTH];
        end
    end

    // o_valid qualifies o and ch for exactly the cycle it is high; the
    // consumer has no back-pressure, so there is no ready.
    always_comb begin
        entry      = !prev_mode;
        eff        = entry ? find_from('0, mask) : find_from(cur, mask);
        nxt_start  = (int'(eff) == N - 1) ? '0 : eff + SW'(1);
        nxt        = find_from(nxt_start, mask);
        cnt_eff    = entry ? '0 : dwell_cnt;
        last_dwell = (cnt_eff == CW'(DWELL - 1));
        sel_ok     = (int'(s) < N) && mask[s];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o         <= '0;
            ch        <= '0;
            o_valid   <= 1'b0;
            wrap      <= 1'b0;
            cur       <= '0;
            dwell_cnt <= '0;
            prev_mode <= 1'b0;
        end else if (!en) begin
            o_valid <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            prev_mode <= mode;
            if (!mode) begin
                o         <= sel_ok ? lane[s] : '0;
                ch        <= s;
                o_valid   <= sel_ok;
                wrap      <= 1'b0;
                cur       <= '0;
                dwell_cnt <= '0;
            end else if (mask == '0) begin
                // Nothing to scan: cur and dwell_cnt hold until a lane returns.
                o       <= '0;
                o_valid <= 1'b0;
                wrap    <= 1'b0;
            end else begin
                o       <= lane[eff];
                ch      <= eff;
                o_valid <= 1'b1;
                if (last_dwell) begin
                    dwell_cnt <= '0;
                    cur       <= nxt;
                    wrap      <= (nxt <= eff);
                end else begin
                    dwell_cnt <= cnt_eff + CW'(1);
                    cur       <= eff;
                    wrap      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_tdm_n.sv
// Bench for mux_tdm_n: directed steps followed by random traffic, all checked
// cycle by cycle against a channel-position reference model.
module tb_mux_tdm_n;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int DWELL = 2;
    localparam int SW    = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               mode;
    logic [SW-1:0]      s;
    logic [N-1:0]       mask;
    logic [N*WIDTH-1:0] d;
    logic [WIDTH-1:0]   o;
    logic [SW-1:0]      ch;
    logic               o_valid;
    logic               wrap;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_o;
    int m_ch;
    int m_valid;
    int m_wrap;
    int m_pos;
    int m_held;
    bit m_in_scan;

    always #5 clk = ~clk;

    mux_tdm_n #(.WIDTH(WIDTH), .N(N), .DWELL(DWELL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .s       (s),
        .mask    (mask),
        .d       (d),
        .o       (o),
        .ch      (ch),
        .o_valid (o_valid),
        .wrap    (wrap)
    );

    function automatic int lane_val(int idx);
        logic [N*WIDTH-1:0] dv;
        dv = d;
        return int'(dv[idx*WIDTH +: WIDTH]);
    endfunction

    function automatic int next_on(int p, logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return p;
    endfunction

    task automatic model_step();
        int e;
        int n;
        if (!rst_n) begin
            m_o = 0; m_ch = 0; m_valid = 0; m_wrap = 0;
            m_pos = 0; m_held = 0; m_in_scan = 1'b0;
        end else if (!en) begin
            m_valid = 0; m_wrap = 0;
        end else if (!mode) begin
            m_ch      = int'(s);
            m_valid   = (int'(s) < N && mask[s]) ? 1 : 0;
            m_o       = (m_valid == 1) ? lane_val(int'(s)) : 0;
            m_wrap    = 0;
            m_pos     = 0;
            m_held    = 0;
            m_in_scan = 1'b0;
        end else begin
            if (!m_in_scan) begin
                m_pos  = 0;
                m_held = 0;
            end
            m_in_scan = 1'b1;
            if (mask == '0) begin
                m_o = 0; m_valid = 0; m_wrap = 0;
            end else begin
                e       = next_on(m_pos, mask);
                m_o     = lane_val(e);
                m_ch    = e;
                m_valid = 1;
                m_held  = m_held + 1;
                if (m_held == DWELL) begin
                    n      = next_on((e + 1) % N, mask);
                    m_wrap = (n <= e) ? 1 : 0;
                    m_pos  = n;
                    m_held = 0;
                end else begin
                    m_pos  = e;
                    m_wrap = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("o", 32'(o), 32'(m_o));
        chk("ch", 32'(ch), 32'(m_ch));
        chk("o_valid", 32'(o_valid), 32'(m_valid));
        chk("wrap", 32'(wrap), 32'(m_wrap));
    endtask

    initial begin
        int exp_ch [9];
        int exp_wr [9];
        exp_ch = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        exp_wr = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

        // reset and manual select
        rst_n = 1'b0; en = 1'b1; mode = 1'b0; s = 2'd2; mask = 4'b1111;
        d = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        tick();
        chk("reset_o", 32'(o), 32'h00);
        chk("reset_valid", 32'(o_valid), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("manual_s2", 32'(o), 32'h33);
        s = 2'd1;
        tick();
        chk("manual_s1", 32'(o), 32'h22);

        // full scan with a directed channel/wrap table
        mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("scan_ch_tbl", 32'(ch), 32'(exp_ch[i]));
            chk("scan_wrap_tbl", 32'(wrap), 32'(exp_wr[i]));
        end

        // masked scan, then empty mask
        mode = 1'b0; tick();
        mode = 1'b1; mask = 4'b1010;
        for (int i = 0; i < 6; i++) tick();
        mask = 4'b0000;
        tick();
        chk("empty_mask_o", 32'(o), 32'h00);
        chk("empty_mask_valid", 32'(o_valid), 32'h0);

        // disable the current channel mid-dwell
        mode = 1'b0; mask = 4'b1111; tick();
        mode = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        mask = 4'b1011;
        tick();
        chk("skip_ch3", 32'(ch), 32'd3);
        chk("skip_o44", 32'(o), 32'h44);
        tick();
        chk("skip_then_ch0", 32'(ch), 32'd0);

        // en stall mid-scan, then an invalid manual select
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        mode = 1'b0; s = 2'd1; mask = 4'b1101;
        tick();
        chk("manual_masked_o", 32'(o), 32'h00);
        chk("manual_masked_valid", 32'(o_valid), 32'h0);

        // mid-scan reset restarts from the lowest enabled channel
        mode = 1'b1; mask = 4'b1111;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; mask = 4'b1100;
        tick();
        chk("post_reset_ch", 32'(ch), 32'd2);
        chk("post_reset_o", 32'(o), 32'h33);

        // single enabled channel wraps every DWELL cycles
        mask = 4'b0100;
        for (int i = 0; i < 6; i++) tick();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
            s = 2'($urandom);
            d = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
